// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS execute stage.
// Single-cycle ops (AND, OR, ADD, SUB, SLT) complete on the sampling edge.
// An iterative unsigned multiply/divide engine writes the HI/LO registers.
// Ports:
//   clk, reset    rising-edge clock, asynchronous active-high reset
//   alu_ctrl      4-bit operation code
//   alu_a, alu_b  operands (dividend / divisor for DIVU)
//   alu_start     request, sampled only while idle
//   alu_result    registered result (LO after MULU/DIVU)
//   alu_zero      registered flag, set when the newly written result is zero
//   alu_hi/alu_lo HI/LO registers
//   alu_busy      high while MULU/DIVU is in flight
//   alu_done      one-cycle pulse when alu_result has been updated
//   alu_illegal   one-cycle pulse with alu_done for an unknown code
module alu_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_a,
    input  logic [WIDTH-1:0] alu_b,
    input  logic             alu_start,
    output logic [WIDTH-1:0] alu_result,
    output logic             alu_zero,
    output logic [WIDTH-1:0] alu_hi,
    output logic [WIDTH-1:0] alu_lo,
    output logic             alu_busy,
    output logic             alu_done,
    output logic             alu_illegal
);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    // MUL: {partial product high, multiplier shifting out}.
    // DIV: low half holds the dividend shifting out / quotient shifting in.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     rem_q, rem_d;     // restoring remainder (always < divisor)
    logic [WIDTH-1:0]     mcand_q, mcand_d; // multiplicand or divisor
    logic                 is_div_q, is_div_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic                 zero_q, zero_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 illegal_q, illegal_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]        single_res;
    logic [WIDTH:0]          mul_sum;
    logic [WIDTH:0]          div_shift;
    logic                    div_ge;

    assign a_s = alu_a;
    assign b_s = alu_b;

    always_comb begin
        single_res = '0;
        case (alu_ctrl)
            OP_AND:  single_res = alu_a & alu_b;
            OP_OR:   single_res = alu_a | alu_b;
            OP_ADD:  single_res = alu_a + alu_b;
            OP_SUB:  single_res = alu_a - alu_b;
            OP_SLT:  single_res = (a_s < b_s) ? WIDTH'(1) : '0;
            default: single_res = '0;
        endcase
    end

    // Shift-add step: conditionally add the multiplicand into the high half,
    // keeping the carry so the right shift brings it back in.
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + {1'b0, ({WIDTH{acc_q[0]}} & mcand_q)};

    // Restoring step: the shifted partial remainder needs WIDTH+1 bits, but
    // after the conditional subtract it is below the divisor and fits WIDTH.
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_ge    = (div_shift >= {1'b0, mcand_q});

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        mcand_d   = mcand_q;
        is_div_d  = is_div_q;
        result_d  = result_q;
        zero_d    = zero_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (alu_start) begin
                    case (alu_ctrl)
                        OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT: begin
                            result_d = single_res;
                            zero_d   = (single_res == '0);
                            done_d   = 1'b1;
                        end
                        OP_MULU: begin
                            acc_d    = {{WIDTH{1'b0}}, alu_a};
                            mcand_d  = alu_b;
                            cnt_d    = CNT_W'(WIDTH);
                            is_div_d = 1'b0;
                            busy_d   = 1'b1;
                            state_d  = MUL;
                        end
                        OP_DIVU: begin
                            mcand_d  = alu_b;
                            is_div_d = 1'b1;
                            busy_d   = 1'b1;
                            if (alu_b == '0) begin
                                // Divide by zero: HI = dividend, LO = all ones.
                                rem_d   = alu_a;
                                acc_d   = {{WIDTH{1'b0}}, {WIDTH{1'b1}}};
                                cnt_d   = '0;
                                state_d = FIN;
                            end else begin
                                rem_d   = '0;
                                acc_d   = {{WIDTH{1'b0}}, alu_a};
                                cnt_d   = CNT_W'(WIDTH);
                                state_d = DIV;
                            end
                        end
                        default: begin
                            result_d  = '0;
                            zero_d    = 1'b1;
                            done_d    = 1'b1;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            DIV: begin
                rem_d = div_ge ? (div_shift[WIDTH-1:0] - mcand_q) : div_shift[WIDTH-1:0];
                acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], div_ge};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = FIN;
            end
            FIN: begin
                hi_d     = is_div_q ? rem_q : acc_q[2*WIDTH-1:WIDTH];
                lo_d     = acc_q[WIDTH-1:0];
                result_d = acc_q[WIDTH-1:0];
                zero_d   = (acc_q[WIDTH-1:0] == '0);
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            mcand_q   <= '0;
            is_div_q  <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b1;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            mcand_q   <= mcand_d;
            is_div_q  <= is_div_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign alu_result  = result_q;
    assign alu_zero    = zero_q;
    assign alu_hi      = hi_q;
    assign alu_lo      = lo_q;
    assign alu_busy    = busy_q;
    assign alu_done    = done_q;
    assign alu_illegal = illegal_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed + randomized bench for alu_muldiv (WIDTH=32).
// Expected values come from a plain-arithmetic reference model.
module tb_alu_muldiv;

    localparam int W = 32;
    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0110;
    localparam logic [3:0] C_SLT  = 4'b0111;
    localparam logic [3:0] C_MULU = 4'b1000;
    localparam logic [3:0] C_DIVU = 4'b1001;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    alu_ctrl;
    logic [W-1:0]  alu_a, alu_b;
    logic          alu_start;
    logic [W-1:0]  alu_result, alu_hi, alu_lo;
    logic          alu_zero, alu_busy, alu_done, alu_illegal;

    int passed = 0;
    int failed = 0;
    int total  = 0;
    logic [W-1:0] m_hi = '0;
    logic [W-1:0] m_lo = '0;

    alu_muldiv dut (
        .clk         (clk),
        .reset       (reset),
        .alu_ctrl    (alu_ctrl),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_start   (alu_start),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_hi      (alu_hi),
        .alu_lo      (alu_lo),
        .alu_busy    (alu_busy),
        .alu_done    (alu_done),
        .alu_illegal (alu_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model for single-cycle codes.
    task automatic model_single(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] res, output logic ill);
        ill = 1'b0;
        case (c)
            C_AND:   res = a & b;
            C_OR:    res = a | b;
            C_ADD:   res = a + b;
            C_SUB:   res = a - b;
            C_SLT:   res = ($signed(a) < $signed(b)) ? 1 : 0;
            default: begin res = '0; ill = 1'b1; end
        endcase
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_result"},  alu_result, 0);
        chk({tag, "_zero"},    alu_zero, 1);
        chk({tag, "_hi"},      alu_hi, 0);
        chk({tag, "_lo"},      alu_lo, 0);
        chk({tag, "_busy"},    alu_busy, 0);
        chk({tag, "_done"},    alu_done, 0);
        chk({tag, "_illegal"}, alu_illegal, 0);
    endtask

    // now=1: drive immediately (caller is already at a negedge, e.g. the done cycle).
    task automatic single(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit now, input bit chk_drop);
        logic [W-1:0] er;
        logic         eil;
        model_single(c, a, b, er, eil);
        if (!now) @(negedge clk);
        alu_ctrl = c; alu_a = a; alu_b = b; alu_start = 1'b1;
        @(negedge clk);
        alu_start = 1'b0;
        chk("single_result",  alu_result, er);
        chk("single_zero",    alu_zero, (er == 0));
        chk("single_done",    alu_done, 1);
        chk("single_illegal", alu_illegal, eil);
        chk("single_busy",    alu_busy, 0);
        chk("single_hi_kept", alu_hi, m_hi);
        chk("single_lo_kept", alu_lo, m_lo);
        if (chk_drop) begin
            @(negedge clk);
            chk("single_done_drop",    alu_done, 0);
            chk("single_illegal_drop", alu_illegal, 0);
        end
    endtask

    // MULU/DIVU; returns at the negedge where alu_done is seen high.
    // disturb: change operands mid-op and fire an ADD request while busy.
    task automatic long_op(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                           input bit disturb);
        logic [63:0]  prod;
        logic [W-1:0] ehi, elo;
        int           lat, n, busy_n;
        if (c == C_MULU) begin
            prod = 64'(a) * 64'(b);
            ehi = prod[63:32];
            elo = prod[31:0];
            lat = W + 2;
        end else if (b == 0) begin
            ehi = a; elo = '1; lat = 2;
        end else begin
            ehi = a % b; elo = a / b; lat = W + 2;
        end
        @(negedge clk);
        alu_ctrl = c; alu_a = a; alu_b = b; alu_start = 1'b1;
        @(negedge clk);
        alu_start = 1'b0;
        n = 1;
        busy_n = 0;
        while (!alu_done && n < 200) begin
            if (alu_busy) busy_n++;
            if (disturb && n == 2) begin
                alu_a = $urandom; alu_b = $urandom;
            end
            if (disturb && n == 4) begin
                alu_ctrl = C_ADD; alu_a = $urandom; alu_b = $urandom; alu_start = 1'b1;
            end
            if (n == 5) alu_start = 1'b0;
            @(negedge clk);
            n++;
        end
        alu_start = 1'b0;
        chk("long_latency",   n, lat);
        chk("long_busy_cyc",  busy_n, lat - 1);
        chk("long_done",      alu_done, 1);
        chk("long_busy_end",  alu_busy, 0);
        chk("long_hi",        alu_hi, ehi);
        chk("long_lo",        alu_lo, elo);
        chk("long_result",    alu_result, elo);
        chk("long_zero",      alu_zero, (elo == 0));
        chk("long_illegal",   alu_illegal, 0);
        m_hi = ehi;
        m_lo = elo;
    endtask

    initial begin
        logic [3:0] ops [7];
        ops = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, 4'b0101, 4'b1111};

        reset = 1'b1;
        alu_start = 1'b0;
        alu_ctrl = '0; alu_a = '0; alu_b = '0;
        repeat (3) @(negedge clk);
        check_reset_state("rst");
        reset = 1'b0;

        // Directed single-cycle ops.
        single(C_ADD, 32'd5, 32'd7, 0, 1);
        single(C_SUB, 32'd9, 32'd9, 0, 1);
        single(C_SLT, 32'hFFFF_FFFF, 32'd1, 0, 1);
        single(C_SLT, 32'd1, 32'hFFFF_FFFF, 0, 1);
        single(C_ADD, 32'hFFFF_FFFF, 32'd1, 0, 1);
        single(4'b0101, 32'd3, 32'd4, 0, 1);

        // Randomized single-cycle ops, back to back.
        for (int i = 0; i < 20; i++)
            single(ops[$urandom_range(0, 6)], $urandom, $urandom, 0, 0);

        // Multiply/divide, directed.
        long_op(C_MULU, 32'hFFFF_FFFF, 32'd2, 1);
        @(negedge clk);
        chk("mul_done_drop", alu_done, 0);
        long_op(C_DIVU, 32'd100, 32'd7, 0);
        long_op(C_DIVU, 32'd123, 32'd0, 0);
        long_op(C_MULU, 32'd0, 32'h1234_5678, 0);

        // ADD ignored while busy, then OR accepted on the done cycle.
        long_op(C_MULU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1);
        single(C_OR, 32'hF0F0_0000, 32'h0000_0F0F, 1, 1);

        // Randomized multiply/divide.
        for (int i = 0; i < 6; i++)
            long_op((i % 2 == 0) ? C_MULU : C_DIVU, $urandom,
                    (i == 5) ? 32'($urandom_range(1, 20)) : $urandom, (i == 1));

        // Asynchronous reset during a MULU.
        @(negedge clk);
        alu_ctrl = C_MULU; alu_a = 32'hFFFF_FFFF; alu_b = 32'hFFFF_FFFF; alu_start = 1'b1;
        @(negedge clk);
        alu_start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        check_reset_state("midrst");
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        chk("midrst_no_done", alu_done, 0);
        chk("midrst_hi_zero", alu_hi, 0);
        long_op(C_DIVU, 32'd1000, 32'd33, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Execute stage of the MIPS datapath, directly downstream of the ALU control decoder.
- Consumes the 4-bit ALU control code plus two register operands and produces a registered result and zero flag.
- Adds an iterative unsigned multiply/divide engine (the mul/div ops the decoder does not yet emit) with HI/LO registers and a start/busy/done handshake, so the controller can stall while it runs.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- alu_ctrl  input  4  operation code: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1000 MULU, 1001 DIVU; all others illegal.
- alu_a  input  WIDTH  operand A (rs); dividend for DIVU.
- alu_b  input  WIDTH  operand B (rt/imm); divisor for DIVU.
- alu_start  input  1  request; sampled only when the engine is idle.
- alu_result  output  WIDTH  registered result; LO after MULU/DIVU.
- alu_zero  output  1  registered, 1 when the newly written alu_result == 0.
- alu_hi  output  WIDTH  HI register: upper product or remainder.
- alu_lo  output  WIDTH  LO register: lower product or quotient.
- alu_busy  output  1  high while a MULU/DIVU is iterating.
- alu_done  output  1  one-cycle pulse when alu_result is updated.
- alu_illegal  output  1  one-cycle pulse with alu_done for an illegal code.

Behaviour:
- Reset (async, any state): alu_result, alu_hi, alu_lo = 0; alu_zero = 1; alu_busy, alu_done, alu_illegal = 0; state IDLE; counter 0. Any in-flight mul/div is discarded and HI/LO are not written.
- States: IDLE, MUL, DIV, FIN.
- IDLE, alu_start=1, single-cycle op:
  - Result is written on the sampling edge; alu_done=1 for the following cycle; state stays IDLE. Latency 1.
  - ADD/SUB wrap modulo 2^WIDTH; no overflow trap.
  - SLT: signed two's-complement compare, result 1 or 0.
  - AND/OR are bitwise.
- IDLE, alu_start=1, illegal code: alu_result=0, alu_zero=1, alu_done=1 and alu_illegal=1 for one cycle.
- IDLE, alu_start=1, MULU/DIVU:
  - Latch operands, counter=WIDTH, go to MUL/DIV; alu_busy=1 from the next cycle.
  - alu_done=0 until the op completes.
- MUL: shift-add, one multiplier bit per edge, 2*WIDTH-bit accumulator. Counter decrements each edge; at 0 go to FIN.
- DIV: restoring division, one quotient bit per edge; remainder width WIDTH+1. Counter decrements each edge; at 0 go to FIN.
- FIN (one edge):
  - Write alu_hi/alu_lo; alu_result=alu_lo; update alu_zero.
  - alu_done=1 for the next cycle; alu_busy=0; return to IDLE.
  - Total: alu_done first high WIDTH+2 edges after the sampling edge (34 for WIDTH=32); alu_busy high WIDTH+1 cycles.
- DIVU with alu_b=0: skip iteration and go straight to FIN with hi=alu_a, lo=all ones. Same FIN timing, so latency is 2.
- alu_start while busy: ignored entirely; no queueing, operands not re-latched.
- alu_start on the cycle alu_done is high: accepted normally (state already IDLE), so ops can run back-to-back.
- Single-cycle ops never modify alu_hi/alu_lo. MULU/DIVU inputs may change after the sampling edge without effect.
- alu_ctrl/alu_a/alu_b are don't-care when alu_start=0. Outputs hold their last value when idle.

Test Plan:
- Reset, then ADD a=5 b=7 start 1 cycle → next cycle alu_result=12, alu_zero=0, alu_done=1 for exactly 1 cycle, alu_busy=0.
- SUB a=9 b=9 → result 0, zero=1. SLT a=0xFFFFFFFF b=1 → result 1. SLT a=1 b=0xFFFFFFFF → result 0.
- MULU a=0xFFFFFFFF b=2 → busy for 33 cycles; done on cycle 34; hi=1, lo=result=0xFFFFFFFE. Operands changed mid-op have no effect.
- DIVU a=100 b=7 → lo=14, hi=2 after 34 cycles. DIVU a=123 b=0 → done after 2 cycles, hi=123, lo=0xFFFFFFFF.
- Start ADD during a busy MULU → ignored, MULU completes correctly. Start OR on the done cycle → result on the next cycle. alu_ctrl=0101 → alu_illegal and alu_done pulse, result=0.
- Assert reset at cycle 10 of a MULU → all outputs at reset values immediately, HI/LO remain 0. A new DIVU afterwards completes correctly.
